fifo_line_unpacker: RTL and testbench
=====================================

Name: fifo_line_unpacker

Overview:
- Downstream consumer of the 256-bit line FIFO in the accelerator datapath.
- Pops full lines, compensating for the FIFO's one-cycle registered dout latency.
- Serializes each line into OUT_W-bit beats on a valid/ready stream feeding the MAC/weight-load stage.
- Holds one prefetched line in a next-line buffer, so the stream runs one beat per cycle across line boundaries.

Parameters:
- LINE_W, 256, FIFO line width in bits.
- OUT_W, 32, output beat width in bits. LINE_W % OUT_W must be 0; BEATS = LINE_W/OUT_W must be >= 2 (elaboration-time assertion).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; abandons the current line, the next line and any in-flight pop.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_dout  input  LINE_W  FIFO registered data; valid in the cycle after a pop.
- fifo_pop  output  1  pop request to the FIFO.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer ready.
- out_data  output  OUT_W  current beat.
- out_last  output  1  high on the final beat (index BEATS-1) of a line.
- busy  output  1  high when any line is held or a pop is in flight.

Behaviour:
- Reset (asynchronous): all outputs 0. Internal state cleared: cur_valid, next_valid, pop_inflight, drop_pending, beat_idx. Line registers need no reset.
- Internal state:
  - cur_q / cur_valid: line being streamed.
  - next_q / next_valid: prefetched line.
  - pop_inflight: pop issued last cycle.
  - drop_pending: discard the arriving data.
  - beat_idx: width $clog2(BEATS), counts 0..BEATS-1.
- fifo_pop = !reset && !flush && !fifo_empty && !pop_inflight && !next_valid && !(cur_valid && next slot would be needed twice).
  - Net effect: at most one line is outstanding beyond cur, so at most 2 lines are held.
  - fifo_pop is combinational from registered state, fifo_empty and flush only. It never depends on out_ready.
- Pop latency: pop asserted in cycle N → pop_inflight=1 in N+1 → fifo_dout captured at the end of N+1.
  - Capture goes into cur_q if cur is free (including when cur retires in the same cycle and next is empty).
  - Otherwise capture goes into next_q.
- Streaming:
  - out_valid = cur_valid.
  - out_data = cur_q[beat_idx*OUT_W +: OUT_W]; beat 0 is the LSBs.
  - out_last = cur_valid && beat_idx == BEATS-1.
  - Handshake is out_valid && out_ready: beat_idx increments, wrapping BEATS-1 → 0. On the last beat, cur retires.
  - out_valid and out_data must remain stable while out_valid && !out_ready.
- Line retirement, same edge:
  - If next_valid: cur_q ← next_q and next_valid ← 0.
  - Else if pop_inflight: cur_q ← fifo_dout.
  - Else cur_valid ← 0.
  - Either way, no bubble between lines once the prefetch is primed.
- Minimum latency: from fifo_empty deasserting with the unpacker idle to out_valid is 2 cycles (pop cycle, capture cycle; out_valid rises in the third).
- flush, registered:
  - Clears cur_valid, next_valid and beat_idx; out_valid drops the next cycle.
  - If pop_inflight, sets drop_pending: data arriving that cycle is discarded, not captured.
  - If flush and pop_inflight coincide, the arriving data is dropped directly.
  - No pop is issued in a flush cycle.
- Boundaries:
  - FIFO empty mid-stream: the current line finishes, then out_valid drops. No spurious pop.
  - out_ready held low indefinitely: at most one prefetched line is held, then popping stops.
  - Reset mid-line: immediate clear. The FIFO is reset on the same reset, so no in-flight data survives.

Optional Feature:
- Macro: LINE_UNPACK_PERF_EN.
- Defined: adds three outputs.
  - perf_lines [31:0]: lines fully retired.
  - perf_stall [31:0]: cycles with out_valid && !out_ready.
  - perf_starve [31:0]: cycles with !cur_valid && !flush while no pop result is available.
  - All three reset to 0, saturate at 2^32-1, and are cleared by flush.
- Undefined: the ports and counters are absent. The rest of the behaviour is identical.

Decomposition:
- Shared package accel_stream_pkg:
  - LINE_W_DEF = 256, OUT_W_DEF = 32.
  - Typedef line_t logic [LINE_W_DEF-1:0].
  - Function beats_per_line(line_w, out_w).
- Sub-module line_slot (one-line register with a valid bit and load/clear), instantiated twice (cur, next). Beat selection stays in the top module.

Test Plan:
- Single line 0x…_0000_0007_…_0001_0000_0000 (word i = i) into an idle unpacker, out_ready=1 → out_data 0,1,…,7 on consecutive cycles; out_last on beat 7; first valid 2 cycles after pop.
- Three back-to-back lines, out_ready=1 → 24 beats with no bubble; fifo_pop asserted exactly 3 times; never 2 pops in adjacent cycles.
- Same three lines with out_ready toggling 1,0,0,1… → beat order preserved; out_data stable during stalls; at most 2 lines popped ahead of consumption.
- flush on beat 3 of line A, with line B's pop in flight → B's data discarded; next output begins with line C, beat 0.
- Async reset asserted mid-line, off the clock edge → out_valid, fifo_pop and busy at 0 immediately; after release, normal streaming resumes from the next FIFO line.
- With LINE_UNPACK_PERF_EN: 2 lines streamed, out_ready low for 5 cycles mid-line → perf_lines=2, perf_stall=5.

Source files
------------

// File: rtl/accel_stream_pkg.sv
// -----------------------------------------------------------------------------
// accel_stream_pkg
//
// Shared definitions for the accelerator line-stream datapath: default line and
// beat widths, the default line type, and a helper that derives the number of
// output beats carried by one FIFO line.
//
// No ports (package). Imported by fifo_line_unpacker and line_slot.
// -----------------------------------------------------------------------------
package accel_stream_pkg;

    localparam int LINE_W_DEF = 256;
    localparam int OUT_W_DEF  = 32;

    typedef logic [LINE_W_DEF-1:0] line_t;

    // Number of OUT_W-bit beats in one LINE_W-bit line.
    function automatic int beats_per_line(input int line_w, input int out_w);
        return line_w / out_w;
    endfunction

endpackage : accel_stream_pkg

// File: rtl/line_slot.sv
// -----------------------------------------------------------------------------
// line_slot
//
// One-line holding register with a valid bit. Used twice by the unpacker: once
// for the line being streamed and once for the prefetched next line.
//
// Ports:
//   clk        clock, all updates on posedge
//   reset      asynchronous active-high reset, clears valid only
//   load       capture load_data and mark the slot valid
//   load_data  line to capture
//   clear      mark the slot empty (load wins if both are high)
//   valid      slot holds a line
//   data       held line (not reset; meaningless while valid is low)
// -----------------------------------------------------------------------------
module line_slot
    import accel_stream_pkg::*;
#(
    parameter int W = LINE_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         clear,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // The wide data register carries no reset; valid qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end
    end

endmodule : line_slot

// File: rtl/fifo_line_unpacker.sv
// -----------------------------------------------------------------------------
// fifo_line_unpacker
//
// Pops LINE_W-bit lines from the upstream line FIFO (registered dout, data valid
// the cycle after the pop) and serializes each line into OUT_W-bit beats on a
// valid/ready stream, beat 0 taken from the line LSBs. A second line slot holds
// a prefetched line so consecutive lines stream with no bubble.
//
// Handshake: a beat transfers on a clock edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_valid, out_data and
// out_last hold their values; out_valid never depends on out_ready.
//
// Optional build macro: LINE_UNPACK_PERF_EN adds perf_lines, perf_stall and
// perf_starve saturating 32-bit counters (cleared by reset and flush).
//
// Ports:
//   clk          clock, all updates on posedge
//   reset        asynchronous active-high reset
//   flush        synchronous; drops current line, next line, in-flight pop
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO registered read data (valid the cycle after fifo_pop)
//   fifo_pop     pop request to the FIFO
//   out_valid    beat valid
//   out_ready    consumer ready
//   out_data     current beat
//   out_last     final beat of a line
//   busy         a line is held or a pop is in flight
//   perf_lines   (LINE_UNPACK_PERF_EN) lines fully retired
//   perf_stall   (LINE_UNPACK_PERF_EN) cycles with out_valid && !out_ready
//   perf_starve  (LINE_UNPACK_PERF_EN) idle cycles with no pop result arriving
// -----------------------------------------------------------------------------
module fifo_line_unpacker
    import accel_stream_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [LINE_W-1:0] fifo_dout,
    output logic              fifo_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
`ifdef LINE_UNPACK_PERF_EN
    ,
    output logic [31:0]       perf_lines,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_starve
`endif
);

    localparam int BEATS = beats_per_line(LINE_W, OUT_W);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (((LINE_W % OUT_W) != 0) || (BEATS < 2)) begin : g_bad_cfg
            $error("fifo_line_unpacker: LINE_W must be a multiple of OUT_W with at least 2 beats");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              cur_valid;
    logic [LINE_W-1:0] cur_q;
    logic              next_valid;
    logic [LINE_W-1:0] next_q;
    logic              pop_inflight;
    logic              drop_pending;
    logic [IDX_W-1:0]  beat_idx;

    // ------------------------------------------------------------------
    // Derived events
    // ------------------------------------------------------------------
    logic last_beat;
    logic fire;
    logic retire;
    logic arrive;
    logic cur_free;
    logic slot_overcommit;

    assign last_beat = (beat_idx == IDX_W'(BEATS - 1));
    assign fire      = cur_valid && out_ready;
    assign retire    = fire && last_beat;

    // Popped data lands this cycle and is kept. A flush in the landing cycle,
    // or one still pending from the previous cycle, discards it.
    assign arrive    = pop_inflight && !drop_pending && !flush;

    // cur can take the arriving line if empty, or if it retires this edge
    // and there is no prefetched line waiting to move in ahead of it.
    assign cur_free  = !cur_valid || (retire && !next_valid);

    // A further pop would need a second next slot once cur is occupied and
    // next is already full or claimed by the pop in flight.
    assign slot_overcommit = cur_valid && (next_valid || pop_inflight);

    // Registered state, fifo_empty and flush only; never out_ready.
    assign fifo_pop = !reset && !flush && !fifo_empty && !pop_inflight
                      && !next_valid && !slot_overcommit;

    // ------------------------------------------------------------------
    // Slot control
    // ------------------------------------------------------------------
    logic              cur_load;
    logic [LINE_W-1:0] cur_load_data;
    logic              cur_clear;
    logic              next_load;
    logic              next_clear;

    always_comb begin
        cur_load      = 1'b0;
        cur_load_data = fifo_dout;
        cur_clear     = 1'b0;
        next_load     = 1'b0;
        next_clear    = 1'b0;

        if (flush) begin
            cur_clear  = 1'b1;
            next_clear = 1'b1;
        end else begin
            if (retire && next_valid) begin
                // Prefetched line moves up; no gap between lines.
                cur_load      = 1'b1;
                cur_load_data = next_q;
                next_clear    = 1'b1;
            end else if (arrive && cur_free) begin
                cur_load      = 1'b1;
                cur_load_data = fifo_dout;
            end else if (retire) begin
                cur_clear     = 1'b1;
            end

            if (arrive && !cur_free) begin
                next_load = 1'b1;
            end
        end
    end

    line_slot #(.W(LINE_W)) u_cur (
        .clk       (clk),
        .reset     (reset),
        .load      (cur_load),
        .load_data (cur_load_data),
        .clear     (cur_clear),
        .valid     (cur_valid),
        .data      (cur_q)
    );

    line_slot #(.W(LINE_W)) u_next (
        .clk       (clk),
        .reset     (reset),
        .load      (next_load),
        .load_data (fifo_dout),
        .clear     (next_clear),
        .valid     (next_valid),
        .data      (next_q)
    );

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_inflight <= 1'b0;
            drop_pending <= 1'b0;
            beat_idx     <= '0;
        end else begin
            pop_inflight <= fifo_pop;
            drop_pending <= flush && pop_inflight;
            if (flush) begin
                beat_idx <= '0;
            end else if (fire) begin
                beat_idx <= last_beat ? '0 : beat_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat selection
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] beat_word [BEATS];

    for (genvar g = 0; g < BEATS; g++) begin : g_beat
        assign beat_word[g] = cur_q[g*OUT_W +: OUT_W];
    end

    // Forced to zero while empty so the unreset line register never shows.
    assign out_valid = cur_valid;
    assign out_data  = cur_valid ? beat_word[beat_idx] : '0;
    assign out_last  = cur_valid && last_beat;
    assign busy      = cur_valid || next_valid || pop_inflight;

`ifdef LINE_UNPACK_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic stall_cycle;
    logic starve_cycle;

    assign stall_cycle  = cur_valid && !out_ready;
    assign starve_cycle = !cur_valid && !flush && !(pop_inflight && !drop_pending);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lines  <= '0;
            perf_stall  <= '0;
            perf_starve <= '0;
        end else if (flush) begin
            perf_lines  <= '0;
            perf_stall  <= '0;
            perf_starve <= '0;
        end else begin
            if (retire && (perf_lines != '1)) begin
                perf_lines <= perf_lines + 32'd1;
            end
            if (stall_cycle && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (starve_cycle && (perf_starve != '1)) begin
                perf_starve <= perf_starve + 32'd1;
            end
        end
    end
`endif

endmodule : fifo_line_unpacker

// File: tb/tb_fifo_line_unpacker.sv
// -----------------------------------------------------------------------------
// tb_fifo_line_unpacker
//
// Directed bench for fifo_line_unpacker with a behavioural line FIFO (queue
// with registered dout) and an expected-beat queue. Build with
// LINE_UNPACK_PERF_EN defined to include the counter scenario.
// -----------------------------------------------------------------------------
module tb_fifo_line_unpacker;
    import accel_stream_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        fifo_empty;
    line_t       fifo_dout;
    logic        fifo_pop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
`ifdef LINE_UNPACK_PERF_EN
    logic [31:0] perf_lines;
    logic [31:0] perf_stall;
    logic [31:0] perf_starve;
`endif

    always #5 clk = ~clk;

    fifo_line_unpacker dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
`ifdef LINE_UNPACK_PERF_EN
        ,
        .perf_lines (perf_lines),
        .perf_stall (perf_stall),
        .perf_starve(perf_starve)
`endif
    );

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int          total = 0;
    int          bad = 0;
    int          pop_count = 0;
    line_t       fifo_q[$];
    logic [31:0] exp_q[$];

    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_pop;
    logic        s_busy;
    logic        s_ready;
`ifdef LINE_UNPACK_PERF_EN
    logic [31:0] s_lines;
    logic [31:0] s_stall;
    logic [31:0] s_starve;
`endif

    function automatic line_t mk_line(input int base);
        line_t l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = 32'(base + i);
        end
        return l;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic push_line(input int base);
        fifo_q.push_back(mk_line(base));
        fifo_empty = 1'b0;
    endtask

    // Called mid-cycle (after negedge) with inputs already set. Samples the
    // cycle's outputs, crosses the clock edge, then updates the FIFO model
    // so a pop shows up on fifo_dout during the following cycle.
    task automatic step();
        #1;
        s_valid = out_valid;
        s_data  = out_data;
        s_last  = out_last;
        s_pop   = fifo_pop;
        s_busy  = busy;
        s_ready = out_ready;
`ifdef LINE_UNPACK_PERF_EN
        s_lines  = perf_lines;
        s_stall  = perf_stall;
        s_starve = perf_starve;
`endif
        @(posedge clk);
        @(negedge clk);
        if (s_pop) begin
            pop_count++;
            total++;
            if (fifo_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_pop: pop with fifo size=%0d, required >0", fifo_q.size());
                fifo_dout = '0;
            end else begin
                fifo_dout = fifo_q.pop_front();
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        fifo_dout = '0;
        fifo_empty = 1'b0;   // FIFO claims data: pop must still stay low in reset
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, fifo_pop, busy, out_last} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: valid/pop/busy/last=%b required 0000",
                     {out_valid, fifo_pop, busy, out_last});
        end
        total++;
        if (out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: out_data=%0h required 0", out_data);
        end
        fifo_empty = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
        total++;
        if ({s_valid, s_pop, s_busy} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: valid/pop/busy=%b required 000", {s_valid, s_pop, s_busy});
        end
    endtask

    task automatic test_single_line();
        out_ready = 1'b1;
        push_line(0);
        step();   // pop cycle
        total++;
        if ({s_pop, s_valid, s_busy} !== 3'b100) begin
            bad++;
            $display("FAIL single_pop_cycle: pop/valid/busy=%b required 100", {s_pop, s_valid, s_busy});
        end
        step();   // capture cycle
        total++;
        if ({s_pop, s_valid, s_busy} !== 3'b001) begin
            bad++;
            $display("FAIL single_capture_cycle: pop/valid/busy=%b required 001", {s_pop, s_valid, s_busy});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (s_valid !== 1'b1 || s_data !== 32'(i) || s_last !== (i == 7) || s_pop !== 1'b0) begin
                bad++;
                $display("FAIL single_beat%0d: valid=%b data=%0h last=%b pop=%b required 1 %0h %b 0",
                         i, s_valid, s_data, s_last, s_pop, i, (i == 7));
            end
        end
        step();
        total++;
        if ({s_valid, s_busy} !== 2'b00) begin
            bad++;
            $display("FAIL single_drain: valid/busy=%b required 00", {s_valid, s_busy});
        end
    endtask

    task automatic test_back_to_back();
        int beats = 0;
        int cycles = 0;
        int pops0;
        logic prev_pop = 1'b0;
        logic started = 1'b0;
        logic [31:0] exp;
        exp_q.delete();
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(32'(100 * (l + 1) + i));
            push_line(100 * (l + 1));
        end
        out_ready = 1'b1;
        pops0 = pop_count;
        while (beats < 24 && cycles < 100) begin
            step();
            cycles++;
            total++;
            if (prev_pop && s_pop) begin
                bad++;
                $display("FAIL b2b_adjacent_pop: pops in adjacent cycles at cycle %0d", cycles);
            end
            prev_pop = s_pop;
            if (started) begin
                total++;
                if (s_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_bubble: valid=%b required 1 after beat %0d", s_valid, beats);
                end
            end
            if (s_valid === 1'b1) begin
                started = 1'b1;
                exp = exp_q.pop_front();
                total++;
                if (s_data !== exp || s_last !== (beats % 8 == 7)) begin
                    bad++;
                    $display("FAIL b2b_beat%0d: data=%0h last=%b required %0h %b",
                             beats, s_data, s_last, exp, (beats % 8 == 7));
                end
                beats++;
            end
        end
        total++;
        if (beats != 24) begin
            bad++;
            $display("FAIL b2b_timeout: beats=%0d required 24", beats);
        end
        total++;
        if (pop_count - pops0 != 3) begin
            bad++;
            $display("FAIL b2b_pop_count: pops=%0d required 3", pop_count - pops0);
        end
        step();
        total++;
        if ({s_valid, s_busy} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_drain: valid/busy=%b required 00", {s_valid, s_busy});
        end
    endtask

    task automatic test_stall_pattern();
        int beats = 0;
        int cycles = 0;
        int retired = 0;
        int pops0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic [31:0] exp;
        exp_q.delete();
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(32'(100 * (l + 1) + i));
            push_line(100 * (l + 1));
        end
        pops0 = pop_count;
        while (beats < 24 && cycles < 300) begin
            out_ready = (cycles % 3 == 0);
            step();
            cycles++;
            if (prev_stall) begin
                total++;
                if (s_valid !== 1'b1 || s_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_stable: valid=%b data=%0h required 1 %0h", s_valid, s_data, prev_data);
                end
            end
            if (s_valid === 1'b1 && s_ready === 1'b1) begin
                exp = exp_q.pop_front();
                total++;
                if (s_data !== exp || s_last !== (beats % 8 == 7)) begin
                    bad++;
                    $display("FAIL stall_beat%0d: data=%0h last=%b required %0h %b",
                             beats, s_data, s_last, exp, (beats % 8 == 7));
                end
                if (beats % 8 == 7) retired++;
                beats++;
            end
            total++;
            if ((pop_count - pops0) - retired > 2) begin
                bad++;
                $display("FAIL stall_ahead: lines ahead=%0d required <=2", (pop_count - pops0) - retired);
            end
            prev_stall = s_valid && !s_ready;
            prev_data  = s_data;
        end
        total++;
        if (beats != 24) begin
            bad++;
            $display("FAIL stall_timeout: beats=%0d required 24", beats);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_ready_low();
        int beats = 0;
        int cycles = 0;
        int pops0;
        logic [31:0] exp;
        exp_q.delete();
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(32'(1000 + 100 * l + i));
            push_line(1000 + 100 * l);
        end
        pops0 = pop_count;
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) step();
        total++;
        if (pop_count - pops0 != 2) begin
            bad++;
            $display("FAIL ready_low_pops: pops=%0d required 2", pop_count - pops0);
        end
        total++;
        if (s_valid !== 1'b1 || s_data !== 32'd1000 || s_busy !== 1'b1) begin
            bad++;
            $display("FAIL ready_low_hold: valid=%b data=%0h busy=%b required 1 3e8 1", s_valid, s_data, s_busy);
        end
        out_ready = 1'b1;
        while (beats < 32 && cycles < 120) begin
            step();
            cycles++;
            if (s_valid === 1'b1) begin
                exp = exp_q.pop_front();
                total++;
                if (s_data !== exp) begin
                    bad++;
                    $display("FAIL ready_low_beat%0d: data=%0h required %0h", beats, s_data, exp);
                end
                beats++;
            end
        end
        total++;
        if (beats != 32 || pop_count - pops0 != 4) begin
            bad++;
            $display("FAIL ready_low_drain: beats=%0d pops=%0d required 32 4", beats, pop_count - pops0);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        push_line(500);                 // line A
        step();                         // c0: pop A
        total++;
        if (s_pop !== 1'b1) begin
            bad++;
            $display("FAIL flush_pop_a: pop=%b required 1", s_pop);
        end
        step();                         // c1: A in flight
        step();                         // c2: A beat 0
        step();                         // c3: A beat 1
        total++;
        if (s_valid !== 1'b1 || s_data !== 32'd501) begin
            bad++;
            $display("FAIL flush_a_beat1: valid=%b data=%0h required 1 1f5", s_valid, s_data);
        end
        push_line(600);                 // line B
        push_line(700);                 // line C
        step();                         // c4: A beat 2, pop B
        total++;
        if (s_pop !== 1'b1 || s_data !== 32'd502) begin
            bad++;
            $display("FAIL flush_pop_b: pop=%b data=%0h required 1 1f6", s_pop, s_data);
        end
        flush = 1'b1;
        step();                         // c5: A beat 3, B in flight, flush
        flush = 1'b0;
        total++;
        if (s_valid !== 1'b1 || s_data !== 32'd503 || s_pop !== 1'b0) begin
            bad++;
            $display("FAIL flush_cycle: valid=%b data=%0h pop=%b required 1 1f7 0", s_valid, s_data, s_pop);
        end
        step();                         // c6: cleared, pop C
        total++;
        if (s_valid !== 1'b0 || s_pop !== 1'b1) begin
            bad++;
            $display("FAIL flush_after: valid=%b pop=%b required 0 1", s_valid, s_pop);
        end
        step();                         // c7: C in flight
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (s_valid !== 1'b1 || s_data !== 32'(700 + i) || s_last !== (i == 7)) begin
                bad++;
                $display("FAIL flush_c_beat%0d: valid=%b data=%0h last=%b required 1 %0h %b",
                         i, s_valid, s_data, s_last, 700 + i, (i == 7));
            end
        end
        step();
        total++;
        if ({s_valid, s_busy} !== 2'b00 || fifo_q.size() != 0) begin
            bad++;
            $display("FAIL flush_drain: valid/busy=%b fifo=%0d required 00 0", {s_valid, s_busy}, fifo_q.size());
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        push_line(800);
        push_line(900);
        for (int c = 0; c < 5; c++) step();   // E beat 2 shown, F prefetched
        push_line(950);
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({out_valid, fifo_pop, busy} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset: valid/pop/busy=%b required 000", {out_valid, fifo_pop, busy});
        end
        fifo_q.delete();                      // FIFO shares the reset
        fifo_empty = 1'b1;
        fifo_dout = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_line(1200);
        step();
        total++;
        if ({s_pop, s_valid} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_pop: pop/valid=%b required 10", {s_pop, s_valid});
        end
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (s_valid !== 1'b1 || s_data !== 32'(1200 + i)) begin
                bad++;
                $display("FAIL post_reset_beat%0d: valid=%b data=%0h required 1 %0h", i, s_valid, s_data, 1200 + i);
            end
        end
        step();
    endtask

`ifdef LINE_UNPACK_PERF_EN
    task automatic test_perf();
        int beats = 0;
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_line(2000);
        push_line(2100);
        for (int c = 0; c < 80 && beats < 16; c++) begin
            out_ready = !(c >= 5 && c < 10);
            step();
            if (c == 0) begin
                total++;
                if (s_lines !== 32'd0 || s_stall !== 32'd0 || s_starve !== 32'd0) begin
                    bad++;
                    $display("FAIL perf_cleared: lines=%0d stall=%0d starve=%0d required 0 0 0",
                             s_lines, s_stall, s_starve);
                end
            end
            if (c == 1) begin
                total++;
                if (s_starve !== 32'd1) begin
                    bad++;
                    $display("FAIL perf_starve: starve=%0d required 1", s_starve);
                end
            end
            if (s_valid === 1'b1 && s_ready === 1'b1) beats++;
        end
        out_ready = 1'b1;
        step();
        step();
        total++;
        if (s_lines !== 32'd2 || s_stall !== 32'd5) begin
            bad++;
            $display("FAIL perf_counts: lines=%0d stall=%0d required 2 5", s_lines, s_stall);
        end
    endtask
`endif

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_stall_pattern();
        test_ready_low();
        test_flush();
        test_async_reset();
`ifdef LINE_UNPACK_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fifo_line_unpacker
